// File: rtl/riscvlong_mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: arbitration mode codes and
// message/ID width helpers matching the core's memory request/response formats.
package riscvlong_mem_arbiter_pkg;

    localparam int RISCVLONG_ARB_FIXED = 0;
    localparam int RISCVLONG_ARB_RR    = 1;

    // Request layout {type, addr, len, data}; response layout {type, len, data}.
    function automatic int mem_len_sz(input int data_sz);
        return $clog2(data_sz / 8);
    endfunction

    function automatic int mem_req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int mem_resp_msg_sz(input int data_sz);
        return 1 + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int arb_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/riscvlong_mem_arbiter_tagq.sv
// Circular FIFO of channel IDs recording which requester owns each in-flight
// request, so in-order responses can be routed back.
module riscvlong_mem_arbiter_tagq
    import riscvlong_mem_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int IDW   = 1,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_push,
    input  logic [IDW-1:0] i_push_id,
    input  logic           i_pop,
    output logic [IDW-1:0] o_head,
    output logic           o_full,
    output logic           o_empty,
    output logic [CW-1:0]  o_count
);

    logic [IDW-1:0] r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_push_id;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/riscvlong_mem_arbiter.sv
// N-channel val/rdy memory-port arbiter: merges requester streams onto one
// memory port and routes in-order responses back to the issuing channel.
module riscvlong_mem_arbiter
    import riscvlong_mem_arbiter_pkg::*;
#(
    parameter  int NUM_CH   = 2,
    parameter  int ADDR_SZ  = 32,
    parameter  int DATA_SZ  = 32,
    parameter  int MAX_OUTS = 4,
    parameter  int ARB_MODE = 1,
    localparam int REQ_SZ   = mem_req_msg_sz(ADDR_SZ, DATA_SZ),
    localparam int RESP_SZ  = mem_resp_msg_sz(DATA_SZ),
    localparam int IDW      = arb_id_width(NUM_CH),
    localparam int CW       = $clog2(MAX_OUTS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*REQ_SZ-1:0]    chreq_msg,
    input  logic [NUM_CH-1:0]           chreq_val,
    output logic [NUM_CH-1:0]           chreq_rdy,
    output logic [NUM_CH*RESP_SZ-1:0]   chresp_msg,
    output logic [NUM_CH-1:0]           chresp_val,
    output logic [REQ_SZ-1:0]           memreq_msg,
    output logic                        memreq_val,
    input  logic                        memreq_rdy,
    input  logic [RESP_SZ-1:0]          memresp_msg,
    input  logic                        memresp_val,
    output logic [CW-1:0]               outstanding,
    output logic                        err
);

    // Handshake: a transfer happens in a cycle where val and rdy are both high;
    // val never waits on rdy, and the response side has no rdy (always consumed).
    logic [IDW-1:0] r_ptr;
    logic           r_err;
    logic [IDW-1:0] w_gnt;
    logic [IDW-1:0] w_head;
    logic           w_any;
    logic           w_adm;
    logic           w_full;
    logic           w_empty;
    logic           w_fire;
    logic           w_pop;
    logic [CW-1:0]  w_count;

    assign w_any = |chreq_val;

    // Fixed mode searches from channel 0; round-robin searches from r_ptr
    // upward first, then wraps to the channels below it.
    always_comb begin
        int   base;
        logic found;
        base  = (ARB_MODE == RISCVLONG_ARB_RR) ? int'(r_ptr) : 0;
        found = 1'b0;
        w_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && chreq_val[i] && i >= base) begin
                w_gnt = IDW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && chreq_val[i]) begin
                w_gnt = IDW'(i);
                found = 1'b1;
            end
        end
    end

    assign w_adm      = ~w_full & ~reset;
    assign memreq_val = w_any & w_adm;
    assign memreq_msg = w_any ? chreq_msg[int'(w_gnt)*REQ_SZ +: REQ_SZ] : '0;
    assign chreq_rdy  = (w_any & memreq_rdy & w_adm) ? (NUM_CH'(1) << w_gnt) : '0;
    assign w_fire     = memreq_val & memreq_rdy;

    // A response with nothing in flight (even one pushed this cycle) is dropped.
    assign w_pop       = memresp_val & ~w_empty & ~reset;
    assign chresp_val  = w_pop ? (NUM_CH'(1) << w_head) : '0;
    assign chresp_msg  = {NUM_CH{memresp_msg}};
    assign outstanding = w_count;
    assign err         = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_fire && ARB_MODE == RISCVLONG_ARB_RR) begin
                r_ptr <= (int'(w_gnt) == NUM_CH - 1) ? '0 : w_gnt + 1'b1;
            end
            if (memresp_val && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    riscvlong_mem_arbiter_tagq #(
        .DEPTH (MAX_OUTS),
        .IDW   (IDW)
    ) u_tagq (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_fire),
        .i_push_id (w_gnt),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

endmodule

// File: tb/tb_riscvlong_mem_arbiter.sv
// Bench for riscvlong_mem_arbiter: a round-robin and a fixed-priority instance
// share stimulus; a reference model predicts grants, routing, count and err.
module tb_riscvlong_mem_arbiter;

    localparam int NUM_CH   = 3;
    localparam int ADDR_SZ  = 32;
    localparam int DATA_SZ  = 32;
    localparam int MAX_OUTS = 4;
    localparam int REQ_SZ   = 1 + ADDR_SZ + 2 + DATA_SZ;
    localparam int RESP_SZ  = 1 + 2 + DATA_SZ;
    localparam int CW       = 3;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_CH*REQ_SZ-1:0]  chreq_msg = '0;
    logic [NUM_CH-1:0]         chreq_val = '0;
    logic                      memreq_rdy = 1'b0;
    logic [RESP_SZ-1:0]        memresp_msg = '0;
    logic                      memresp_val = 1'b0;

    logic [NUM_CH-1:0]         a_chreq_rdy, b_chreq_rdy;
    logic [NUM_CH*RESP_SZ-1:0] a_chresp_msg, b_chresp_msg;
    logic [NUM_CH-1:0]         a_chresp_val, b_chresp_val;
    logic [REQ_SZ-1:0]         a_memreq_msg, b_memreq_msg;
    logic                      a_memreq_val, b_memreq_val;
    logic [CW-1:0]             a_outstanding, b_outstanding;
    logic                      a_err, b_err;

    riscvlong_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_SZ(ADDR_SZ), .DATA_SZ(DATA_SZ), .MAX_OUTS(MAX_OUTS), .ARB_MODE(1)
    ) u_rr (
        .clk(clk), .reset(reset), .chreq_msg(chreq_msg), .chreq_val(chreq_val), .chreq_rdy(a_chreq_rdy),
        .chresp_msg(a_chresp_msg), .chresp_val(a_chresp_val), .memreq_msg(a_memreq_msg),
        .memreq_val(a_memreq_val), .memreq_rdy(memreq_rdy), .memresp_msg(memresp_msg),
        .memresp_val(memresp_val), .outstanding(a_outstanding), .err(a_err)
    );

    riscvlong_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_SZ(ADDR_SZ), .DATA_SZ(DATA_SZ), .MAX_OUTS(MAX_OUTS), .ARB_MODE(0)
    ) u_fx (
        .clk(clk), .reset(reset), .chreq_msg(chreq_msg), .chreq_val(chreq_val), .chreq_rdy(b_chreq_rdy),
        .chresp_msg(b_chresp_msg), .chresp_val(b_chresp_val), .memreq_msg(b_memreq_msg),
        .memreq_val(b_memreq_val), .memreq_rdy(memreq_rdy), .memresp_msg(memresp_msg),
        .memresp_val(memresp_val), .outstanding(b_outstanding), .err(b_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int qa[$];
    int qb[$];
    int m_ptr = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_CH-1:0] v, input int p);
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int fixed_pick(input logic [NUM_CH-1:0] v);
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Monitor: outputs are settled mid-cycle; compare, then advance the model
    // exactly as the coming rising edge will.
    always @(negedge clk) begin : mon
        int  ga, gb, ea, eb;
        bit  room, fire;
        if (reset) begin
            chk("rst_memreq_val_a", a_memreq_val, 0);
            chk("rst_memreq_val_b", b_memreq_val, 0);
            chk("rst_chreq_rdy_a", a_chreq_rdy, 0);
            chk("rst_chreq_rdy_b", b_chreq_rdy, 0);
            chk("rst_chresp_val_a", a_chresp_val, 0);
            chk("rst_outstanding_a", a_outstanding, 0);
            chk("rst_outstanding_b", b_outstanding, 0);
            chk("rst_err_a", a_err, 0);
            chk("rst_err_b", b_err, 0);
            qa.delete();
            qb.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            ga   = rr_pick(chreq_val, m_ptr);
            gb   = fixed_pick(chreq_val);
            room = (qa.size() < MAX_OUTS);
            fire = (chreq_val != 0) && room && memreq_rdy;
            chk("outstanding_a", a_outstanding, qa.size());
            chk("outstanding_b", b_outstanding, qb.size());
            chk("err_a", a_err, m_err);
            chk("err_b", b_err, m_err);
            chk("memreq_val_a", a_memreq_val, (chreq_val != 0) && room);
            chk("memreq_val_b", b_memreq_val, (chreq_val != 0) && room);
            if (ga >= 0) begin
                chk("memreq_msg_a", a_memreq_msg, chreq_msg[ga*REQ_SZ +: REQ_SZ]);
                chk("memreq_msg_b", b_memreq_msg, chreq_msg[gb*REQ_SZ +: REQ_SZ]);
                chk("chreq_rdy_a", a_chreq_rdy, (memreq_rdy && room) ? (1 << ga) : 0);
                chk("chreq_rdy_b", b_chreq_rdy, (memreq_rdy && room) ? (1 << gb) : 0);
            end else begin
                chk("memreq_msg_idle_a", a_memreq_msg, 0);
                chk("memreq_msg_idle_b", b_memreq_msg, 0);
            end
            if (memresp_val && qa.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("chresp_val_a", a_chresp_val, 1 << ea);
                chk("chresp_val_b", b_chresp_val, 1 << eb);
                chk("chresp_msg_a", a_chresp_msg, {NUM_CH{memresp_msg}});
                chk("chresp_msg_b", b_chresp_msg, {NUM_CH{memresp_msg}});
            end else begin
                chk("chresp_val_none_a", a_chresp_val, 0);
                chk("chresp_val_none_b", b_chresp_val, 0);
                if (memresp_val) m_err = 1'b1;
            end
            if (fire) begin
                qa.push_back(ga);
                qb.push_back(gb);
                m_ptr = (ga + 1) % NUM_CH;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reqs(input logic [NUM_CH-1:0] v);
        logic [95:0] r;
        chreq_val = v;
        for (int i = 0; i < NUM_CH; i++) begin
            r = {$urandom, $urandom, $urandom};
            chreq_msg[i*REQ_SZ +: REQ_SZ] = r[REQ_SZ-1:0];
        end
    endtask

    // Memory model: answers in order, only for requests that fired earlier.
    task automatic mem_drive(input int pct);
        logic [63:0] r;
        r = {$urandom, $urandom};
        memresp_val = (qa.size() > 0) && ($urandom_range(0, 99) < pct);
        memresp_msg = memresp_val ? r[RESP_SZ-1:0] : '0;
    endtask

    task automatic run_random(input int cycles, input int resp_pct);
        for (int c = 0; c < cycles; c++) begin
            set_reqs(NUM_CH'($urandom_range(0, 7)));
            memreq_rdy = ($urandom_range(0, 3) != 0);
            mem_drive(resp_pct);
            step();
        end
    endtask

    task automatic drain();
        chreq_val = '0;
        for (int c = 0; c < 40; c++) begin
            mem_drive(100);
            step();
        end
        memresp_val = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();

        // ch1 reads 0x1000; memory answers 0xDEADBEEF two cycles later.
        memreq_rdy = 1'b1;
        chreq_val  = 3'b010;
        chreq_msg[1*REQ_SZ +: REQ_SZ] = {1'b0, 32'h0000_1000, 2'b00, 32'h0};
        step();
        chreq_val = '0;
        step();
        step();
        memresp_val = 1'b1;
        memresp_msg = {1'b0, 2'b00, 32'hDEAD_BEEF};
        step();
        memresp_val = 1'b0;
        step();

        // All channels valid with a sustained stream of responses.
        memreq_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            set_reqs(3'b111);
            mem_drive(100);
            step();
        end
        drain();

        // Fill to MAX_OUTS, then answer while full: admission waits a cycle.
        memreq_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_reqs(3'b111);
            step();
        end
        mem_drive(100);
        step();
        memresp_val = 1'b0;
        step();
        drain();

        run_random(800, 30);
        run_random(800, 75);
        drain();

        // Stray response in the same cycle as a first push is dropped.
        memreq_rdy  = 1'b1;
        set_reqs(3'b001);
        memresp_val = 1'b1;
        memresp_msg = RESP_SZ'(35'h5_1234_5678);
        step();
        memresp_val = 1'b0;
        run_random(60, 50);
        drain();

        // Three outstanding from ch1, then an asynchronous reset mid-cycle.
        memreq_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_reqs(3'b010);
            step();
        end
        chreq_val = '0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_outstanding_a", a_outstanding, 0);
        chk("async_rst_outstanding_b", b_outstanding, 0);
        chk("async_rst_err_a", a_err, 0);
        chk("async_rst_err_b", b_err, 0);
        chk("async_rst_memreq_val_a", a_memreq_val, 0);
        step();
        step();
        reset = 1'b0;
        set_reqs(3'b111);
        step();
        run_random(300, 50);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscvlong_mem_arbiter.md
# riscvlong_mem_arbiter

Parametrised N-channel memory-port arbiter that merges several val/rdy memory request streams (e.g. imem, dmem, future prefetcher) onto one shared memory port and routes in-order responses back to the originating channel. It sits between the core's request ports and a single-ported memory or cache, and uses the same `VC_MEM_REQ_MSG` and `VC_MEM_RESP_MSG` bit formats as the core ports. It supports fixed-priority or round-robin arbitration, with a bounded number of outstanding requests tracked in a channel-ID queue.

## Interface
Parameters:
- NUM_CH, 2, number of requester channels (2..8)
- ADDR_SZ, 32, request address width
- DATA_SZ, 32, data width
- MAX_OUTS, 4, maximum in-flight requests (power of 2, 2..16)
- ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin

Ports (REQ_SZ = `VC_MEM_REQ_MSG_SZ(ADDR_SZ,DATA_SZ)`, RESP_SZ = `VC_MEM_RESP_MSG_SZ(DATA_SZ)`, IDW = max(1,clog2(NUM_CH)), CW = clog2(MAX_OUTS+1)):
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- chreq_msg  in  NUM_CH*REQ_SZ  per-channel request; channel i occupies bits [i*REQ_SZ +: REQ_SZ]
- chreq_val  in  NUM_CH  per-channel request valid
- chreq_rdy  out  NUM_CH  per-channel request ready
- chresp_msg  out  NUM_CH*RESP_SZ  per-channel response; all slices carry memresp_msg
- chresp_val  out  NUM_CH  per-channel response valid (one-hot or zero)
- memreq_msg  out  REQ_SZ  shared request
- memreq_val  out  1  shared request valid
- memreq_rdy  in  1  shared request ready
- memresp_msg  in  RESP_SZ  shared response
- memresp_val  in  1  shared response valid; no ready, must be consumed
- outstanding  out  CW  number of in-flight requests
- err  out  1  sticky protocol error (response with no outstanding request)

## Operation
- Grant is combinational from chreq_val and the priority pointer. It does not depend on memreq_rdy.
- ARB_MODE 0: the lowest-index valid channel wins.
- ARB_MODE 1: the first valid channel at or after ptr (circular) wins.
- memreq_val = (|chreq_val) & !full & !reset.
- memreq_msg = the granted channel's message. It is 0 when nothing is valid.
- chreq_rdy[g] = memreq_rdy & !full & !reset for the granted g. All other channels see 0.
- Fire = memreq_val & memreq_rdy. On fire:
  - push the grant ID into the tag queue;
  - in mode 1, ptr <= (g+1) mod NUM_CH;
  - ptr is unchanged when there is no fire.
- Response:
  - when memresp_val is high and the queue is non-empty, chresp_val[head] = 1 and the head is popped;
  - chresp_msg is broadcast to every slice.
- Response with the queue empty (including the same cycle as the first push): chresp_val stays 0, the response is dropped, and err is set to 1 until reset.
- Full: outstanding == MAX_OUTS. Full is evaluated on the registered count, with no same-cycle pop bypass. A response arriving while full does not admit a new request in that cycle.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Pointers wrap modulo MAX_OUTS.
- Reset (asynchronous, any time, including mid-transaction):
  - ptr = 0, queue head = tail = 0, outstanding = 0, err = 0;
  - memreq_val, chreq_rdy and chresp_val are forced to 0 while reset is high;
  - in-flight responses arriving after reset deassert set err. The memory must be reset together with the arbiter.

## Timing
- Request path and response path are both combinational pass-through (0-cycle latency).
- State (ptr, queue, count, err) updates on the rising clk edge.
- Throughput: 1 request and 1 response per cycle sustained.
- The shared memory must return responses in request order, at least 1 cycle after fire.

## Structure
- Shared header `riscvlong-MemArbiterDefs.v` holds:
  - `RISCVLONG_ARB_FIXED` = 0 and `RISCVLONG_ARB_RR` = 1;
  - the ID-width helper macro.
- Message size macros come from the existing `vc-MemReqMsg.v` and `vc-MemRespMsg.v`.
- One sub-module, `riscvlong_mem_arbiter_tagq`: a circular FIFO of IDW-bit channel IDs, depth MAX_OUTS, with:
  - push and pop inputs;
  - head, full, empty and count outputs;
  - asynchronous active-high reset.

## Test plan
- Single channel: ch1 reads addr 0x1000, memory responds 2 cycles later with data 0xDEADBEEF -> chresp_val = 2'b10, data 0xDEADBEEF, outstanding goes 1 then 0.
- Round-robin, NUM_CH = 3, all channels valid continuously, memreq_rdy = 1 -> grants 0,1,2,0,1,2. Fixed mode with the same stimulus -> grants 0,0,0,...
- Full: MAX_OUTS = 4, 4 requests with no response -> outstanding = 4, memreq_val = 0. A response arriving in the same cycle -> no new fire in that cycle, fire on the next cycle.
- Interleaving: requests ch0, ch1, ch0 with responses 0xA, 0xB, 0xC -> routed to ch0, ch1, ch0 in order. Simultaneous push and pop keeps outstanding constant.
- Stray response: memresp_val with outstanding = 0 -> no chresp_val, err = 1 and it stays 1 until reset.
- Reset mid-operation: assert reset with 3 outstanding -> outstanding = 0, err = 0 and ptr = 0 immediately without a clock edge; normal operation resumes after deassert.
